// File: rtl/e_mdu_pkg.sv
// Shared types and helpers for the E-stage multiply/divide unit.
// Op encodings match the decoder and hazard unit view of MDU-class instrs.
// Division helper works on magnitudes so INT_MIN / -1 wraps cleanly.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Signed divide: quotient truncates toward zero, remainder takes the
  // dividend's sign. Caller must not use the result for a zero divisor.
  function automatic hilo_t sdiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q;
    logic [31:0] r;
    hilo_t       res;
    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b[31] ? (~b + 32'd1) : b;
    if (b_mag == 32'd0) b_mag = 32'd1;
    q      = a_mag / b_mag;
    r      = a_mag % b_mag;
    res.lo = (a[31] ^ b[31]) ? (~q + 32'd1) : q;
    res.hi = a[31] ? (~r + 32'd1) : r;
    return res;
  endfunction

  function automatic logic is_long_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; results computed at start, committed later.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles after the start cycle.
// Backpressure: E_MDUBusy high from start cycle through last busy cycle; hazard unit stalls D.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  output logic        E_MDUBusy,
  output logic [31:0] E_MDUOut
);

  mdu_op_e     op;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic [3:0]  cnt;
  logic        busy;
  logic        start_cyc;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  hilo_t       res;

  assign op        = mdu_op_e'(E_MDUOp);
  assign start_cyc = is_long_op(op) & ~Req & ~busy;
  assign E_MDUBusy = start_cyc | busy;

  // Full 64-bit products from explicitly extended operands.
  assign prod_s = {{32{E_V1[31]}}, E_V1} * {{32{E_V2[31]}}, E_V2};
  assign prod_u = {32'd0, E_V1} * {32'd0, E_V2};

  // Result to park in pend_hi/pend_lo; a zero divisor re-parks the current HI/LO.
  always_comb begin
    res = '0;
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        if (E_V2 == 32'd0) res = '{hi: hi, lo: lo};
        else               res = sdiv(E_V1, E_V2);
      end
      MDU_DIVU: begin
        if (E_V2 == 32'd0) res = '{hi: hi, lo: lo};
        else               res = '{hi: E_V1 % E_V2, lo: E_V1 / E_V2};
      end
      default:   res = '0;
    endcase
  end

  // mfhi/mflo read the architectural registers directly.
  assign E_MDUOut = (op == MDU_MFHI) ? hi :
                    (op == MDU_MFLO) ? lo : 32'd0;

  // HI/LO, pending results and busy countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (busy) begin
      // In-flight op belongs to a committed instr: Req does not stop it,
      // and any new op arriving now is ignored.
      if (cnt == 4'd1) begin
        hi   <= pend_hi;
        lo   <= pend_lo;
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (!Req) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          pend_hi <= res.hi;
          pend_lo <= res.lo;
          cnt     <= 4'(MULT_CYCLES);
          busy    <= 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          pend_hi <= res.hi;
          pend_lo <= res.lo;
          cnt     <= 4'(DIV_CYCLES);
          busy    <= 1'b1;
        end
        MDU_MTHI: hi <= E_V1;
        MDU_MTLO: lo <= E_V1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results and busy-window lengths.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A global watchdog bounds the run.
module tb_e_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        E_MDUBusy;
  logic [31:0] E_MDUOut;

  int total = 0;
  int bad   = 0;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .E_MDUOp   (E_MDUOp),
    .E_V1      (E_V1),
    .E_V2      (E_V2),
    .E_MDUBusy (E_MDUBusy),
    .E_MDUOut  (E_MDUOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a long op for one cycle, then count E_MDUBusy-high cycles including the start cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles);
    int n;
    n = 0;
    next_cycle();
    E_MDUOp = op; E_V1 = a; E_V2 = b;
    @(negedge clk);
    if (E_MDUBusy) n++;
    next_cycle();
    E_MDUOp = OP_NONE;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!E_MDUBusy) break;
      n++;
    end
    chk(tag, n, exp_cycles);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    next_cycle();
    E_MDUOp = OP_MFHI;
    @(negedge clk);
    chk({tag, "_hi"}, E_MDUOut, exp_hi);
    next_cycle();
    E_MDUOp = OP_MFLO;
    @(negedge clk);
    chk({tag, "_lo"}, E_MDUOut, exp_lo);
    next_cycle();
    E_MDUOp = OP_NONE;
  endtask

  task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] v, input logic req);
    next_cycle();
    E_MDUOp = op; E_V1 = v; Req = req;
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, E_MDUBusy}, 32'd0);
    next_cycle();
    E_MDUOp = OP_NONE; Req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Req = 1'b0; E_MDUOp = OP_NONE; E_V1 = '0; E_V2 = '0;
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, E_MDUBusy}, 32'd0);
    chk("rst_out_none", E_MDUOut, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    // mult -2 * 3 = -6
    run_op("mult_busy", OP_MULT, 32'hFFFF_FFFE, 32'd3, 6);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
    run_op("multu_busy", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 6);
    read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // mult INT_MIN * INT_MIN = 2^62
    run_op("mult_min_busy", OP_MULT, 32'h8000_0000, 32'h8000_0000, 6);
    read_hilo("mult_min", 32'h4000_0000, 32'h0000_0000);

    // div -7 / 2 = -3 rem -1
    run_op("div_busy", OP_DIV, 32'hFFFF_FFF9, 32'd2, 11);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // div INT_MIN / -1 wraps to INT_MIN rem 0
    run_op("div_ovf_busy", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 11);
    read_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

    // divu 0xFFFFFFFF / 16
    run_op("divu_busy", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 11);
    read_hilo("divu", 32'h0000_000F, 32'h0FFF_FFFF);

    // divu by zero keeps HI/LO
    move_to("mthi11", OP_MTHI, 32'h11, 1'b0);
    move_to("mtlo22", OP_MTLO, 32'h22, 1'b0);
    run_op("divu0_busy", OP_DIVU, 32'h8000_0000, 32'd0, 11);
    read_hilo("divu0", 32'h11, 32'h22);

    // mthi squashed by Req, then accepted
    move_to("mthi_req", OP_MTHI, 32'hDEAD_BEEF, 1'b1);
    read_hilo("mthi_req", 32'h11, 32'h22);
    move_to("mthi_ok", OP_MTHI, 32'hDEAD_BEEF, 1'b0);
    read_hilo("mthi_ok", 32'hDEAD_BEEF, 32'h22);

    // div squashed by Req: no busy, no effect
    next_cycle();
    E_MDUOp = OP_DIV; E_V1 = 32'd100; E_V2 = 32'd7; Req = 1'b1;
    @(negedge clk);
    chk("div_req_busy", {31'd0, E_MDUBusy}, 32'd0);
    next_cycle();
    E_MDUOp = OP_NONE; Req = 1'b0;
    @(negedge clk);
    chk("div_req_after", {31'd0, E_MDUBusy}, 32'd0);
    read_hilo("div_req", 32'hDEAD_BEEF, 32'h22);

    // Req during busy cycle 3 does not stop the op; mfhi while busy sees old HI
    next_cycle();
    E_MDUOp = OP_DIV; E_V1 = 32'd100; E_V2 = 32'd7;
    next_cycle();
    E_MDUOp = OP_MFHI;
    @(negedge clk);
    chk("busy_mfhi_old", E_MDUOut, 32'hDEAD_BEEF);
    next_cycle();
    E_MDUOp = OP_NONE;
    next_cycle();
    Req = 1'b1;
    @(negedge clk);
    chk("req_busy_hi", {31'd0, E_MDUBusy}, 32'd1);
    next_cycle();
    Req = 1'b0;
    begin
      int n;
      n = 3;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!E_MDUBusy) break;
        n++;
      end
      chk("req_mid_busy", n, 10);
    end
    read_hilo("req_mid", 32'd2, 32'd14);

    // Req at busy cycle 3, then reset at busy cycle 6 aborts the op
    next_cycle();
    E_MDUOp = OP_DIVU; E_V1 = 32'd1000; E_V2 = 32'd3;
    next_cycle();
    E_MDUOp = OP_NONE;
    next_cycle();
    next_cycle();
    Req = 1'b1;
    next_cycle();
    Req = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, E_MDUBusy}, 32'd1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, E_MDUBusy}, 32'd0);
    read_hilo("mid_rst", 32'd0, 32'd0);
    repeat (12) next_cycle();
    read_hilo("post_rst", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
